// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, stall/redirect controls from later
// stages, and the registered instruction stream handed to decode.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [INSTR_WIDTH-1:0] mem_instruction;
    logic                   stall;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic [INSTR_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0]  ir_pc;
    logic                   ir_valid;
    logic                   halted;

    // Fetch-stage view
    modport master (
        output mem_address,
        input  mem_instruction,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output ir,
        output ir_pc,
        output ir_valid,
        output halted
    );

    // Memory / pipeline view
    modport slave (
        input  mem_address,
        output mem_instruction,
        output stall,
        output redirect_valid,
        output redirect_target,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational memory address, registered IR.
// Halt-opcode detection and the HALTED state are built only with IFETCH_HALT_DETECT_EN.
module instruction_fetch #(
    parameter int                  ADDR_WIDTH  = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 16'h0000,
    parameter logic [2:0]          HALT_OPCODE = 3'b011
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0]  PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]  PC_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [INSTR_WIDTH-1:0] IR_NOP   = {INSTR_WIDTH{1'b0}};

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] instr);
        return (instr[INSTR_WIDTH-1 -: 3] == HALT_OPCODE);
    endfunction

    logic [ADDR_WIDTH-1:0]  pc_q,       pc_d;
    logic [INSTR_WIDTH-1:0] ir_q,       ir_d;
    logic [ADDR_WIDTH-1:0]  ir_pc_q,    ir_pc_d;
    logic                   ir_valid_q, ir_valid_d;

`ifdef IFETCH_HALT_DETECT_EN
    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic         halted_q;

    // Next-state selection: redirect beats stall beats normal fetch
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        state_d    = state_q;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_target;
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    ir_d       = bus.mem_instruction;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    // A fetched halt is issued once, but the PC stays on it
                    if (is_halt(bus.mem_instruction)) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
                ST_HALTED: begin
                    ir_valid_d = 1'b0;
                end
                default: begin
                    state_d    = ST_FETCH;
                    ir_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Fetch state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= IR_NOP;
            ir_pc_q    <= PC_ZERO;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    assign bus.halted = halted_q;
`else
    // Next-state selection: redirect beats stall beats normal fetch
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_target;
            ir_valid_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else begin
            ir_d       = bus.mem_instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_ONE;
        end
    end

    // Fetch registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= IR_NOP;
            ir_pc_q    <= PC_ZERO;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign bus.halted = 1'b0;
`endif

    assign bus.mem_address = pc_q;
    assign bus.ir          = ir_q;
    assign bus.ir_pc       = ir_pc_q;
    assign bus.ir_valid    = ir_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stall/redirect traffic checked against a transaction-level reference model.
module tb_instruction_fetch;

    logic clk;
    logic reset;

    instruction_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) bus ();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:65535];
    assign bus.mem_instruction = mem[bus.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the fetch stage
    logic [15:0] m_pc, m_ir, m_ir_pc;
    logic        m_valid, m_halted;

    function automatic logic [49:0] model_vec();
        return {m_ir, m_ir_pc, m_valid, m_halted, m_pc};
    endfunction

    function automatic logic [49:0] dut_vec();
        return {bus.ir, bus.ir_pc, bus.ir_valid, bus.halted, bus.mem_address};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 16'h0000; m_ir_pc = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic rv, input logic [15:0] rt);
        logic [15:0] instr;
        if (rv) begin
            m_pc = rt; m_valid = 1'b0; m_halted = 1'b0;
        end else if (s) begin
            // everything held
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else begin
            instr   = mem[m_pc];
            m_ir    = instr;
            m_ir_pc = m_pc;
            m_valid = 1'b1;
            if (HALT_EN && instr[15:13] == 3'b011) m_halted = 1'b1;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic drive_cycle(input logic s, input logic rv, input logic [15:0] rt);
        bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = rt;
        model_edge(s, rv, rt);
        @(posedge clk);
        #1;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 50'd0)
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 50'd0);
        if (dut_vec() !== 50'd0) n_fail++;
    endtask

    task automatic test_free_run();
        logic [15:0] exp_ir [0:2];
        exp_ir[0] = 16'hA000; exp_ir[1] = 16'hA405; exp_ir[2] = 16'hA801;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 16'h0000);
            n_checks++;
            if (bus.ir !== exp_ir[i] || bus.ir_pc !== 16'(i) || bus.ir_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got ir=%h pc=%h v=%b expected ir=%h pc=%h v=1",
                         i, bus.ir, bus.ir_pc, bus.ir_valid, exp_ir[i], 16'(i));
            end
        end
    endtask

    task automatic test_stall();
        repeat (2) drive_cycle(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 16'h0000);
            n_checks++;
            if (bus.ir_pc !== 16'h0004 || bus.mem_address !== 16'h0005 || bus.ir !== mem[4]) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got pc=%h addr=%h ir=%h expected pc=0004 addr=0005 ir=%h",
                         i, bus.ir_pc, bus.mem_address, bus.ir, mem[4]);
            end
        end
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus.ir_pc !== 16'h0005 || bus.ir_valid !== 1'b1 || bus.mem_address !== 16'h0006) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h v=%b addr=%h expected pc=0005 v=1 addr=0006",
                     bus.ir_pc, bus.ir_valid, bus.mem_address);
        end
    endtask

    task automatic test_redirect();
        drive_cycle(1'b1, 1'b1, 16'h0003);
        n_checks++;
        if (bus.mem_address !== 16'h0003 || bus.ir_valid !== 1'b0 || bus.ir_pc !== 16'h0005) begin
            n_fail++;
            $display("FAIL redirect_bubble: got addr=%h v=%b pc=%h expected addr=0003 v=0 pc=0005",
                     bus.mem_address, bus.ir_valid, bus.ir_pc);
        end
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus.ir_pc !== 16'h0003 || bus.ir_valid !== 1'b1 || bus.ir !== mem[3]) begin
            n_fail++;
            $display("FAIL redirect_target: got pc=%h v=%b ir=%h expected pc=0003 v=1 ir=%h",
                     bus.ir_pc, bus.ir_valid, bus.ir, mem[3]);
        end
    endtask

    task automatic test_halt();
        mem[16'h000E] = 16'h6000;
        drive_cycle(1'b0, 1'b1, 16'h000E);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus.ir !== 16'h6000 || bus.ir_pc !== 16'h000E || bus.ir_valid !== 1'b1 ||
            bus.halted !== HALT_EN || bus.mem_address !== (HALT_EN ? 16'h000E : 16'h000F)) begin
            n_fail++;
            $display("FAIL halt_capture: got ir=%h pc=%h v=%b h=%b addr=%h", bus.ir, bus.ir_pc,
                     bus.ir_valid, bus.halted, bus.mem_address);
        end
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL halt_after: got %h expected %h", dut_vec(), model_vec());
        end
`ifdef IFETCH_HALT_DETECT_EN
        n_checks++;
        if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1 || bus.mem_address !== 16'h000E) begin
            n_fail++;
            $display("FAIL halt_freeze: got v=%b h=%b addr=%h expected v=0 h=1 addr=000E",
                     bus.ir_valid, bus.halted, bus.mem_address);
        end
        drive_cycle(1'b0, 1'b1, 16'h0000);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus.halted !== 1'b0 || bus.ir_pc !== 16'h0000 || bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b pc=%h v=%b expected h=0 pc=0000 v=1",
                     bus.halted, bus.ir_pc, bus.ir_valid);
        end
`else
        n_checks++;
        if (bus.ir_pc !== 16'h000F || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ignored: got pc=%h h=%b expected pc=000F h=0", bus.ir_pc, bus.halted);
        end
`endif
    endtask

    task automatic test_wrap();
        drive_cycle(1'b0, 1'b1, 16'hFFFF);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (bus.mem_address !== 16'h0000 || bus.ir_pc !== 16'hFFFF || bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: got addr=%h pc=%h v=%b expected addr=0000 pc=FFFF v=1",
                     bus.mem_address, bus.ir_pc, bus.ir_valid);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 1'b0, 16'h0000);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec() !== 50'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), 50'd0);
        end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (dut_vec() !== model_vec() || bus.ir_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_resume: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) mem[$urandom_range(0, 255)] = 16'h6000 | 16'($urandom_range(0, 255));
        for (int i = 0; i < 400; i++) begin
            logic s, rv;
            logic [15:0] rt;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 9) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                              : 16'($urandom_range(0, 255));
            drive_cycle(s, rv, rt);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int a = 0; a < 65536; a++) begin
            v = 16'($urandom);
            if (v[15:13] == 3'b011) v[15:13] = 3'b111;
            mem[a] = v;
        end
        mem[0] = 16'hA000; mem[1] = 16'hA405; mem[2] = 16'hA801;
        reset = 1'b1;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 16'h0000;
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
